maq_h: RTL and testbench

Hours stage of the digital clock, directly downstream of the minutes counter. Holds the hour as two BCD digits (00–23) and advances when the minutes stage is at 59 and a minute-advance tick arrives. Provides a set mode in which a push button increments the hour, with auto-repeat while the button is held. Emits a one-cycle day-rollover pulse for a future date stage.

---
 rtl/maq_pkg.sv | 18 +
 rtl/maq_btn_rep.sv | 75 +++++++
 rtl/maq_h.sv | 101 ++++++++++
 tb/tb_maq_h.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/maq_pkg.sv
// -----------------------------------------------------------------------------
// maq_pkg - shared definitions for the hours stage of the digital clock.
//   btn_st_e             : button auto-repeat FSM states
//   HOUR_MSD_MAX         : highest legal tens digit (2)
//   HOUR_LSD_MAX_AT_MSD2 : highest legal units digit when tens = 2 (3)
//   LSD_MAX              : highest BCD units digit (9)
// -----------------------------------------------------------------------------
package maq_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } btn_st_e;

  localparam logic [1:0] HOUR_MSD_MAX         = 2'd2;
  localparam logic [3:0] HOUR_LSD_MAX_AT_MSD2 = 4'd3;
  localparam logic [3:0] LSD_MAX              = 4'd9;
endpackage

// File: rtl/maq_btn_rep.sv
// -----------------------------------------------------------------------------
// maq_btn_rep - set-mode button handler with hold-then-repeat behaviour.
// Ports:
//   i_clk       : clock
//   i_rst_n     : synchronous active-low reset
//   i_set_mode  : FSM only runs while high; low forces IDLE, no pulses
//   i_btn       : debounced button level
//   o_inc_pulse : one-cycle increment request (decoded from state + inputs,
//                 consumed by the hour register on the same edge)
// -----------------------------------------------------------------------------
module maq_btn_rep
  import maq_pkg::*;
#(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 12_500_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_set_mode,
  input  logic i_btn,
  output logic o_inc_pulse
);
  localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  btn_st_e       r_st, w_nxt;
  logic [CW-1:0] r_cnt;
  logic          w_cnt_clr;

  // state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_st <= IDLE;
    else          r_st <= w_nxt;
  end

  // next-state logic
  always_comb begin
    w_nxt = r_st;
    if (!i_set_mode) begin
      w_nxt = IDLE;
    end else begin
      case (r_st)
        IDLE:    if (i_btn) w_nxt = HOLD;
        HOLD:    if (!i_btn) w_nxt = IDLE;
                 else if (r_cnt == HOLD_LAST) w_nxt = REPEAT;
        REPEAT:  if (!i_btn) w_nxt = IDLE;
        default: w_nxt = IDLE;
      endcase
    end
  end

  // outputs: increment pulse and counter clear
  always_comb begin
    o_inc_pulse = 1'b0;
    if (i_set_mode) begin
      case (r_st)
        IDLE:    o_inc_pulse = i_btn;
        HOLD:    o_inc_pulse = i_btn && (r_cnt == HOLD_LAST);
        REPEAT:  o_inc_pulse = i_btn && (r_cnt == REP_LAST);
        default: o_inc_pulse = 1'b0;
      endcase
    end
    // every increment restarts the interval; IDLE keeps it parked at 0
    w_cnt_clr = !i_set_mode || (r_st == IDLE) || o_inc_pulse;
  end

  // cycle counter, saturating at all-ones instead of wrapping
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)          r_cnt <= '0;
    else if (w_cnt_clr)    r_cnt <= '0;
    else if (r_cnt != '1)  r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/maq_h.sv
// -----------------------------------------------------------------------------
// maq_h - hours stage of the digital clock (BCD 00..23).
// Optional feature: define MAQH_12H_EN for a 12 h display with PM flag.
// Ports:
//   maqh_clock    : clock
//   reset         : synchronous active-low reset
//   enable_1hz    : 1 Hz tick
//   inc_min       : minute-advance qualifier
//   maqh_inc_hora : minutes carry level (minutes = 59)
//   set_mode      : manual setting mode, suspends normal counting
//   btn_inc       : debounced increment button level
//   maqh_lsd      : hour units digit (BCD)
//   maqh_msd      : hour tens digit (BCD)
//   maqh_pm       : PM flag (12 h build only, else 0)
//   maqh_day_tick : one-cycle pulse on run-mode 23 -> 00 rollover
// -----------------------------------------------------------------------------
module maq_h
  import maq_pkg::*;
#(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 12_500_000
) (
  input  logic       maqh_clock,
  input  logic       reset,
  input  logic       enable_1hz,
  input  logic       inc_min,
  input  logic       maqh_inc_hora,
  input  logic       set_mode,
  input  logic       btn_inc,
  output logic [3:0] maqh_lsd,
  output logic [1:0] maqh_msd,
  output logic       maqh_pm,
  output logic       maqh_day_tick
);
  logic [1:0] r_msd;
  logic [3:0] r_lsd;
  logic       r_day;
  logic       w_set_inc, w_run_adv, w_adv, w_at_max;

  maq_btn_rep #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_btn (
    .i_clk      (maqh_clock),
    .i_rst_n    (reset),
    .i_set_mode (set_mode),
    .i_btn      (btn_inc),
    .o_inc_pulse(w_set_inc)
  );

  // carries arriving in set mode are dropped, never replayed
  assign w_run_adv = !set_mode && enable_1hz && inc_min && maqh_inc_hora;
  assign w_adv     = w_run_adv || w_set_inc;
  assign w_at_max  = (r_msd == HOUR_MSD_MAX) && (r_lsd == HOUR_LSD_MAX_AT_MSD2);

  always_ff @(posedge maqh_clock) begin
    if (!reset) begin
      r_msd <= '0;
      r_lsd <= '0;
      r_day <= 1'b0;
    end else begin
      r_day <= w_run_adv && w_at_max;
      if (w_adv) begin
        if (w_at_max) begin
          r_msd <= '0;
          r_lsd <= '0;
        end else if (r_lsd == LSD_MAX) begin
          r_msd <= r_msd + 1'b1;
          r_lsd <= '0;
        end else begin
          r_lsd <= r_lsd + 1'b1;
        end
      end
    end
  end

  assign maqh_day_tick = r_day;

`ifdef MAQH_12H_EN
  logic [4:0] w_h24, w_h12, w_tmp;
  always_comb begin
    w_h24 = ({3'b0, r_msd} * 5'd10) + {1'b0, r_lsd};
    if (w_h24 == 5'd0)       w_h12 = 5'd12;
    else if (w_h24 > 5'd12)  w_h12 = w_h24 - 5'd12;
    else                     w_h12 = w_h24;
    w_tmp   = w_h12 - 5'd10;
    maqh_pm = (w_h24 >= 5'd12);
    if (w_h12 >= 5'd10) begin
      maqh_msd = 2'd1;
      maqh_lsd = w_tmp[3:0];
    end else begin
      maqh_msd = 2'd0;
      maqh_lsd = w_h12[3:0];
    end
  end
`else
  assign maqh_msd = r_msd;
  assign maqh_lsd = r_lsd;
  assign maqh_pm  = 1'b0;
`endif
endmodule

// File: tb/tb_maq_h.sv
module tb_maq_h;
  logic       clk = 1'b0;
  logic       reset, enable_1hz, inc_min, maqh_inc_hora, set_mode, btn_inc;
  logic [3:0] maqh_lsd;
  logic [1:0] maqh_msd;
  logic       maqh_pm, maqh_day_tick;

  int n_tests = 0;
  int n_fail  = 0;
  int ref_h   = 0;

  always #5 clk = ~clk;

  maq_h #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut (
    .maqh_clock   (clk),
    .reset        (reset),
    .enable_1hz   (enable_1hz),
    .inc_min      (inc_min),
    .maqh_inc_hora(maqh_inc_hora),
    .set_mode     (set_mode),
    .btn_inc      (btn_inc),
    .maqh_lsd     (maqh_lsd),
    .maqh_msd     (maqh_msd),
    .maqh_pm      (maqh_pm),
    .maqh_day_tick(maqh_day_tick)
  );

  // one clock; outputs are sampled and inputs changed 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected display {msd,lsd,pm} for an internal 24 h hour value
  function automatic logic [7:0] disp(input int h);
    int d, p;
`ifdef MAQH_12H_EN
    p = (h >= 12) ? 1 : 0;
    d = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
`else
    p = 0;
    d = h;
`endif
    return {1'b0, 2'(d / 10), 4'(d % 10), 1'(p)};
  endfunction

  task automatic chk_hour(input string tag, input int h);
    chk(tag, {1'b0, maqh_msd, maqh_lsd, maqh_pm}, disp(h));
  endtask

  task automatic run_adv(input logic hora);
    enable_1hz = 1'b1; inc_min = 1'b1; maqh_inc_hora = hora;
    tick();
    enable_1hz = 1'b0; inc_min = 1'b0; maqh_inc_hora = 1'b0;
  endtask

  task automatic run_to(input int h);
    while (ref_h != h) begin
      run_adv(1'b1);
      ref_h = (ref_h + 1) % 24;
    end
  endtask

  initial begin
    int nexp;
    // reset with random inputs
    reset = 1'b0;
    enable_1hz = 1'($urandom); inc_min = 1'($urandom); maqh_inc_hora = 1'($urandom);
    set_mode = 1'($urandom); btn_inc = 1'($urandom);
    tick(); tick();
    chk_hour("reset_hour", 0);
    chk("reset_day", {7'b0, maqh_day_tick}, 8'd0);
    reset = 1'b1; enable_1hz = 0; inc_min = 0; maqh_inc_hora = 0; set_mode = 0; btn_inc = 0;
    tick();
    chk_hour("idle_hold", 0);

    // run carry 09 -> 10, and no carry without maqh_inc_hora
    run_to(9);
    chk_hour("at_09", 9);
    run_adv(1'b1); ref_h = 10;
    chk("carry_09_10", {2'b0, maqh_msd, maqh_lsd}, 8'h10);
    run_adv(1'b0);
    chk("no_hora_carry", {2'b0, maqh_msd, maqh_lsd}, 8'h10);

    // 19 -> 20 with no day tick
    run_to(19);
    run_adv(1'b1); ref_h = 20;
    chk("carry_19_20", {2'b0, maqh_msd, maqh_lsd}, 8'h20);
    chk("no_tick_19", {7'b0, maqh_day_tick}, 8'd0);

    // 23 -> 00 with exactly one day tick
    run_to(23);
    chk("at_23", {2'b0, maqh_msd, maqh_lsd}, 8'h23);
    run_adv(1'b1); ref_h = 0;
    chk("roll_23_00", {2'b0, maqh_msd, maqh_lsd}, 8'h00);
    chk("day_tick_on", {7'b0, maqh_day_tick}, 8'd1);
    tick();
    chk("day_tick_off", {7'b0, maqh_day_tick}, 8'd0);

`ifdef MAQH_12H_EN
    chk("h12_00", {1'b0, maqh_msd, maqh_lsd, maqh_pm}, 8'b0_01_0010_0);
    run_to(11);
    chk("h12_11", {1'b0, maqh_msd, maqh_lsd, maqh_pm}, 8'b0_01_0001_0);
    run_to(12);
    chk("h12_12", {1'b0, maqh_msd, maqh_lsd, maqh_pm}, 8'b0_01_0010_1);
    run_to(13);
    chk("h12_13", {1'b0, maqh_msd, maqh_lsd, maqh_pm}, 8'b0_00_0001_1);
`else
    run_to(13);
    chk("pm_tied_0", {7'b0, maqh_pm}, 8'd0);
`endif

    // set mode: press at 22, hold 20 cycles; increments at edges 0,8,12,16
    run_to(22);
    set_mode = 1'b1;
    tick();
    chk_hour("set_no_btn", 22);
    btn_inc = 1'b1;
    for (int k = 0; k < 20; k++) begin
      // a run carry in set mode must be ignored
      if (k == 3) begin enable_1hz = 1; inc_min = 1; maqh_inc_hora = 1; end
      tick();
      enable_1hz = 0; inc_min = 0; maqh_inc_hora = 0;
      nexp = (k >= 0) + (k >= 8) + (k >= 12) + (k >= 16);
      chk_hour($sformatf("set_k%0d", k), (22 + nexp) % 24);
      chk($sformatf("set_tick_k%0d", k), {7'b0, maqh_day_tick}, 8'd0);
    end
    ref_h = 2;

    // reset while in REPEAT with button held
    reset = 1'b0;
    tick();
    chk_hour("midrst_hour", 0);
    reset = 1'b1;
    tick();
    chk_hour("post_rst_press", 1);
    tick();
    chk_hour("post_rst_hold", 1);

    // leaving set mode with the button held: no increment
    set_mode = 1'b0;
    tick(); tick();
    chk_hour("exit_set_held", 1);
    // entering set mode with button held counts as a press
    set_mode = 1'b1;
    tick();
    chk_hour("enter_set_held", 2);
    btn_inc = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk_hour("released_stable", 2);
    set_mode = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
